// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared types and constants for the boot-time program loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Loader sequencing states; DONE and ERROR are terminal until reset
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        DONE    = 3'd3,
        ERROR   = 3'd4
    } state_t;

    // Word that terminates a program image; never written to memory
    localparam logic [31:0] C_EOP_WORD_DEFAULT = 32'h0000_0FFF;

    // Byte position within the word being assembled (0..3)
    localparam int unsigned C_BYTE_CNT_W = 2;

endpackage
`default_nettype wire

// File: rtl/prog_loader_timeout.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_timeout
// Description : Inter-byte watchdog for the program loader. Counts enabled
//               cycles since the last clear and flags expiry on the cycle the
//               count reaches TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned       C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [C_CNT_W-1:0] r_cnt;

    // Count enabled cycles since the last received byte, saturating at the limit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != C_LAST)) begin
            r_cnt <= r_cnt + C_CNT_W'(1);
        end
    end

    // The cycle that would make the count reach the limit is the expiry cycle
    assign expired_o = en_i && !clr_i && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_ctrl
// Description : Boot-time program loader. Assembles UART bytes into 32-bit
//               little-endian words, writes them to sequential instruction
//               memory addresses over a req/gnt port and releases the core
//               reset once the end-of-program word is received.
//               Optional inter-byte watchdog: define PROG_LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader_ctrl
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 10,
    parameter int unsigned MEM_DEPTH      = 1024,
    parameter logic [31:0] EOP_WORD       = C_EOP_WORD_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_byte_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_rst_no,
    output logic              prog_done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   words_o
);

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [C_BYTE_CNT_W-1:0] r_byte_cnt;
    logic [31:0]             r_word;
    logic                    r_cmp_pending;   // fourth byte captured, compare this cycle
    logic                    r_skid_vld;
    logic [7:0]              r_skid_byte;
    logic [ADDR_W-1:0]       r_mem_addr;
    logic [31:0]             r_mem_wdata;
    logic [ADDR_W:0]         r_words;

    logic                    w_is_eop;
    logic                    w_full;
    logic                    w_overrun;
    logic                    w_timeout;

    assign w_is_eop  = (r_word == EOP_WORD);
    assign w_full    = (r_words == (ADDR_W + 1)'(MEM_DEPTH));
    // A byte arriving while the single skid slot is occupied cannot be kept
    assign w_overrun = (r_state == WRITE) && rx_valid_i && r_skid_vld;

`ifdef PROG_LOADER_TIMEOUT_EN
    logic w_wd_en;

    // Watchdog runs while mid-word; a stalled write with a parked byte is not
    // the programmer's fault, so it pauses then
    assign w_wd_en = (r_state == COLLECT) || ((r_state == WRITE) && !r_skid_vld);

    prog_loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (rx_valid_i),
        .en_i      (w_wd_en),
        .expired_o (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (rx_valid_i) begin
                    w_state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                if (r_cmp_pending) begin
                    if (w_is_eop) begin
                        w_state_nxt = DONE;
                    end else if (w_full) begin
                        w_state_nxt = ERROR;
                    end else begin
                        w_state_nxt = WRITE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ERROR;
                end
            end
            WRITE: begin
                if (w_overrun) begin
                    w_state_nxt = ERROR;
                end else if (mem_gnt_i) begin
                    w_state_nxt = COLLECT;
                end else if (w_timeout) begin
                    w_state_nxt = ERROR;
                end
            end
            DONE:    w_state_nxt = DONE;
            ERROR:   w_state_nxt = ERROR;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the current state and datapath registers
    always_comb begin
        mem_req_o   = (r_state == WRITE);
        core_rst_no = (r_state == DONE);
        prog_done_o = (r_state == DONE);
        err_o       = (r_state == ERROR);
        mem_addr_o  = r_mem_addr;
        mem_wdata_o = r_mem_wdata;
        words_o     = r_words;
    end

    // Word assembly, skid buffer, write address/data and word counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_byte_cnt    <= '0;
            r_word        <= '0;
            r_cmp_pending <= 1'b0;
            r_skid_vld    <= 1'b0;
            r_skid_byte   <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_words       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rx_valid_i) begin
                        r_word[7:0] <= rx_byte_i;
                        r_byte_cnt  <= C_BYTE_CNT_W'(1);
                    end
                end
                COLLECT: begin
                    if (r_cmp_pending) begin
                        r_cmp_pending <= 1'b0;
                        // A byte during the compare cycle belongs to the next word
                        if (rx_valid_i) begin
                            r_skid_vld  <= 1'b1;
                            r_skid_byte <= rx_byte_i;
                        end
                        if (!w_is_eop && !w_full) begin
                            r_mem_wdata <= r_word;
                            r_mem_addr  <= r_words[ADDR_W-1:0];
                        end
                    end else if (rx_valid_i) begin
                        r_word[8*r_byte_cnt +: 8] <= rx_byte_i;
                        r_byte_cnt                <= r_byte_cnt + C_BYTE_CNT_W'(1);
                        if (r_byte_cnt == C_BYTE_CNT_W'(3)) begin
                            r_cmp_pending <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_gnt_i) begin
                        r_words    <= r_words + (ADDR_W + 1)'(1);
                        r_skid_vld <= 1'b0;
                        // Parked byte (or one arriving now) starts the next word
                        if (r_skid_vld) begin
                            r_word[7:0] <= r_skid_byte;
                            r_byte_cnt  <= C_BYTE_CNT_W'(1);
                        end else if (rx_valid_i) begin
                            r_word[7:0] <= rx_byte_i;
                            r_byte_cnt  <= C_BYTE_CNT_W'(1);
                        end else begin
                            r_byte_cnt  <= '0;
                        end
                    end else if (rx_valid_i && !r_skid_vld) begin
                        r_skid_vld  <= 1'b1;
                        r_skid_byte <= rx_byte_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader_ctrl
// Description : Self-checking bench for prog_loader_ctrl. An expected-write
//               queue built from the program image is compared against every
//               cycle the memory request is raised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader_ctrl;

    localparam int          ADDR_W         = 10;
    localparam int          MEM_DEPTH      = 8;
    localparam int          TIMEOUT_CYCLES = 100;
    localparam logic [31:0] EOP            = 32'h0000_0FFF;

    logic              clk_i      = 1'b0;
    logic              rst_ni     = 1'b0;
    logic              rx_valid_i = 1'b0;
    logic [7:0]        rx_byte_i  = 8'h00;
    logic              mem_gnt_i  = 1'b0;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              core_rst_no;
    logic              prog_done_o;
    logic              err_o;
    logic [ADDR_W:0]   words_o;

    int vectors     = 0;
    int miscompares = 0;
    int gnt_mode    = 1;   // 0: random with bounded stall, 1: always grant, 2: never grant
    int stall       = 0;

    // Expected writes in order: {address, data}
    logic [ADDR_W+31:0] exp_q[$];

    prog_loader_ctrl #(
        .ADDR_W         (ADDR_W),
        .MEM_DEPTH      (MEM_DEPTH),
        .EOP_WORD       (EOP),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_valid_i  (rx_valid_i),
        .rx_byte_i   (rx_byte_i),
        .mem_req_o   (mem_req_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .core_rst_no (core_rst_no),
        .prog_done_o (prog_done_o),
        .err_o       (err_o),
        .words_o     (words_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Grant driver and write monitor: every request cycle must present the
    // address/data of the oldest outstanding expected write
    always @(negedge clk_i) begin
        case (gnt_mode)
            0:       mem_gnt_i = mem_req_o && ((stall >= 2) || ($urandom_range(0, 1) == 1));
            1:       mem_gnt_i = 1'b1;
            default: mem_gnt_i = 1'b0;
        endcase
        if (mem_req_o && !mem_gnt_i) stall++;
        else                         stall = 0;
        if (rst_ni && mem_req_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_req", 64'(mem_req_o), 64'd0);
            end else begin
                check("wr_addr", 64'(mem_addr_o), 64'(exp_q[0][ADDR_W+31:32]));
                check("wr_data", 64'(mem_wdata_o), 64'(exp_q[0][31:0]));
                if (mem_gnt_i) void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w == EOP) w = 32'h1;
        return w;
    endfunction

    task automatic expect_write(input int addr, input logic [31:0] data);
        exp_q.push_back({ADDR_W'(addr), data});
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk_i);
        rx_valid_i = 1'b1;
        rx_byte_i  = b;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni     = 1'b0;
        rx_valid_i = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic wait_end(input int budget);
        for (int i = 0; i < budget && !(prog_done_o || err_o); i++) @(negedge clk_i);
        check("load_end_seen", 64'(prog_done_o | err_o), 64'd1);
    endtask

    task automatic final_checks(input int exp_words, input bit exp_done);
        check("prog_done", 64'(prog_done_o), 64'(exp_done));
        check("core_rst_n", 64'(core_rst_no), 64'(exp_done));
        check("err", 64'(err_o), 64'(!exp_done));
        check("words", 64'(words_o), 64'(exp_words));
        check("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  b0, b1, b2, b3;
        int          n;

        // Reset values
        repeat (2) @(negedge clk_i);
        check("rst_req", 64'(mem_req_o), 64'd0);
        check("rst_addr", 64'(mem_addr_o), 64'd0);
        check("rst_wdata", 64'(mem_wdata_o), 64'd0);
        check("rst_core_rst_n", 64'(core_rst_no), 64'd0);
        check("rst_done", 64'(prog_done_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_words", 64'(words_o), 64'd0);
        rst_ni = 1'b1;

        // Basic load with grant tied high, including compare-cycle latency
        gnt_mode = 1;
        expect_write(0, 32'h0000_0013);
        expect_write(1, 32'h0010_0093);
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("req_in_compare_cycle", 64'(mem_req_o), 64'd0);
        @(negedge clk_i);
        check("req_after_compare", 64'(mem_req_o), 64'd1);
        send_word(32'h0010_0093, 0);
        send_byte(8'hFF, 0); send_byte(8'h0F, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        check("done_in_compare_cycle", 64'(prog_done_o), 64'd0);
        @(negedge clk_i);
        final_checks(2, 1'b1);

        // Bytes after completion are ignored
        send_word(rand_word(), 2);
        repeat (4) @(negedge clk_i);
        final_checks(2, 1'b1);

        // Immediate end-of-program
        do_reset();
        send_word(EOP, 2);
        repeat (3) @(negedge clk_i);
        final_checks(0, 1'b1);

        // Backpressure: one byte parked during a long stall starts the next word
        do_reset();
        gnt_mode = 2;
        w = rand_word();
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        expect_write(0, w);
        expect_write(1, {b3, b2, b1, b0});
        send_word(w, 0);
        repeat (5) @(negedge clk_i);
        send_byte(b0, 0);
        repeat (14) @(negedge clk_i);
        check("req_held_under_stall", 64'(mem_req_o), 64'd1);
        gnt_mode = 1;
        send_byte(b1, 2); send_byte(b2, 2); send_byte(b3, 2);
        send_word(EOP, 2);
        wait_end(50);
        final_checks(2, 1'b1);

        // Overrun: second byte during a stall aborts the load
        do_reset();
        gnt_mode = 2;
        w = rand_word();
        expect_write(0, w);
        send_word(w, 0);
        repeat (3) @(negedge clk_i);
        send_byte(8'($urandom), 0);
        send_byte(8'($urandom), 0);
        check("overrun_err", 64'(err_o), 64'd1);
        check("overrun_core_rst_n", 64'(core_rst_no), 64'd0);
        check("overrun_done", 64'(prog_done_o), 64'd0);
        check("overrun_words", 64'(words_o), 64'd0);
        exp_q.delete();

        // Capacity: one word more than the memory holds
        do_reset();
        gnt_mode = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            w = rand_word();
            expect_write(i, w);
            send_word(w, 4);
        end
        send_word(rand_word(), 4);
        repeat (4) @(negedge clk_i);
        final_checks(MEM_DEPTH, 1'b0);

        // Reset mid-load, then a fresh load restarts at address 0
        do_reset();
        gnt_mode = 0;
        for (int i = 0; i < 2; i++) begin
            w = rand_word();
            expect_write(i, w);
            send_word(w, 4);
        end
        send_byte(8'($urandom), 4);
        send_byte(8'($urandom), 4);
        do_reset();
        check("words_after_reset", 64'(words_o), 64'd0);
        check("req_after_reset", 64'(mem_req_o), 64'd0);
        w = rand_word();
        expect_write(0, w);
        send_word(w, 4);
        send_word(EOP, 4);
        wait_end(50);
        final_checks(1, 1'b1);

        // Stalled programmer: three bytes then silence
        do_reset();
        gnt_mode = 1;
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk_i);
        check("err_before_timeout", 64'(err_o), 64'd0);
        @(negedge clk_i);
`ifdef PROG_LOADER_TIMEOUT_EN
        check("err_at_timeout", 64'(err_o), 64'd1);
`else
        check("err_at_timeout", 64'(err_o), 64'd0);
`endif
        check("core_rst_n_stalled", 64'(core_rst_no), 64'd0);

        // Randomized program images with random grant timing and byte gaps
        for (int it = 0; it < 6; it++) begin
            do_reset();
            gnt_mode = 0;
            n = $urandom_range(0, MEM_DEPTH);
            for (int i = 0; i < n; i++) begin
                w = rand_word();
                expect_write(i, w);
                send_word(w, $urandom_range(4, 7));
            end
            send_word(EOP, 4);
            wait_end(100);
            final_checks(n, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
